// File: rtl/demux_1to8_seq.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to8_seq
// Brief    : 1-to-8 demultiplexer with registered lanes; addressed mode steers
//            din to lane sel, sequential mode deserializes an LSB-first frame.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to8_seq #(
    parameter int LANES = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_n,
    input  logic             mode,
    input  logic             start,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] data,
    output logic [LANES-1:0] data_n,
    output logic [SEL_W-1:0] cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] c_LAST_LANE = SEL_W'(LANES - 1);

    state_t           r_state;
    logic [LANES-1:0] r_data;
    logic [SEL_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!en_n) begin
                        if (!mode) begin
                            r_data[sel] <= din;
                        end else if (start) begin
                            // The start edge only clears the frame; din is not captured.
                            r_data  <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (!en_n) begin
                        r_data[r_cnt] <= din;
                        if (r_cnt == c_LAST_LANE) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + SEL_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    // Single presentation cycle; all controls are ignored here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data   = r_data;
    assign data_n = ~r_data;
    assign cnt    = r_cnt;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to8_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to8_seq
// Brief    : Self-checking bench for demux_1to8_seq (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to8_seq;

    logic       clk;
    logic       rst;
    logic       en_n;
    logic       mode;
    logic       start;
    logic       din;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] data_n;
    logic [2:0] cnt;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    demux_1to8_seq #(.LANES(8), .SEL_W(3)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .en_n   (en_n),
        .mode   (mode),
        .start  (start),
        .din    (din),
        .sel    (sel),
        .data   (data),
        .data_n (data_n),
        .cnt    (cnt),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       en_n;
        logic       mode;
        logic       start;
        logic       din;
        logic [2:0] sel;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic r, logic e, logic m, logic s, logic d,
                                logic [2:0] sl, logic [7:0] ed, logic [2:0] ec,
                                logic eb, logic edn);
        vec_t v;
        v.name = nm; v.rst = r; v.en_n = e; v.mode = m; v.start = s; v.din = d;
        v.sel = sl; v.e_data = ed; v.e_cnt = ec; v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ed, input logic [2:0] ec,
                           input logic eb, input logic edn);
        chk({nm, ".data"},   data,         ed);
        chk({nm, ".data_n"}, data_n,       ~ed);
        chk({nm, ".cnt"},    {5'd0, cnt},  {5'd0, ec});
        chk({nm, ".busy"},   {7'd0, busy}, {7'd0, eb});
        chk({nm, ".done"},   {7'd0, done}, {7'd0, edn});
    endtask

    // Drive one set of inputs across a rising edge, settle 1 time unit after it.
    task automatic cyc(input logic r, input logic e, input logic m, input logic s,
                       input logic d, input logic [2:0] sl);
        rst = r; en_n = e; mode = m; start = s; din = d; sel = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] frame;
        logic [7:0] exp_d;
        int         done_seen;

        rst = 1'b1; en_n = 1'b0; mode = 1'b0; start = 1'b0; din = 1'b0; sel = 3'd0;

        vecs.push_back(mk("rst0",  1, 0, 0, 0, 1, 3'd5, 8'h00, 3'd0, 0, 0));
        vecs.push_back(mk("rst1",  1, 0, 1, 1, 1, 3'd2, 8'h00, 3'd0, 0, 0));
        vecs.push_back(mk("addr3", 0, 0, 0, 0, 1, 3'd3, 8'h08, 3'd0, 0, 0));
        vecs.push_back(mk("addr6", 0, 0, 0, 0, 1, 3'd6, 8'h48, 3'd0, 0, 0));
        vecs.push_back(mk("hold",  0, 1, 0, 0, 1, 3'd0, 8'h48, 3'd0, 0, 0));
        vecs.push_back(mk("clr3",  0, 0, 0, 0, 0, 3'd3, 8'h40, 3'd0, 0, 0));
        vecs.push_back(mk("start", 0, 0, 1, 1, 1, 3'd0, 8'h00, 3'd0, 1, 0));
        vecs.push_back(mk("b0",    0, 0, 1, 0, 1, 3'd0, 8'h01, 3'd1, 1, 0));
        vecs.push_back(mk("b1",    0, 0, 1, 0, 0, 3'd0, 8'h01, 3'd2, 1, 0));
        vecs.push_back(mk("b2",    0, 0, 1, 0, 1, 3'd0, 8'h05, 3'd3, 1, 0));
        vecs.push_back(mk("b3",    0, 0, 1, 0, 1, 3'd0, 8'h0D, 3'd4, 1, 0));
        vecs.push_back(mk("b4",    0, 0, 1, 0, 0, 3'd0, 8'h0D, 3'd5, 1, 0));
        vecs.push_back(mk("b5",    0, 0, 1, 0, 0, 3'd0, 8'h0D, 3'd6, 1, 0));
        vecs.push_back(mk("b6",    0, 0, 1, 0, 1, 3'd0, 8'h4D, 3'd7, 1, 0));
        vecs.push_back(mk("b7",    0, 0, 1, 0, 0, 3'd0, 8'h4D, 3'd0, 0, 1));
        vecs.push_back(mk("idle",  0, 0, 1, 0, 1, 3'd0, 8'h4D, 3'd0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].en_n, vecs[i].mode, vecs[i].start, vecs[i].din, vecs[i].sel);
            chk_all(vecs[i].name, vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_done);
        end

        // Stall at cnt=4 for three cycles, then finish frame 8'h4D.
        frame = 8'h4D;
        cyc(0, 0, 1, 1, 0, 3'd0);
        chk_all("st_start", 8'h00, 3'd0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, frame[i], 3'd0);
        chk_all("st_pre", 8'h0D, 3'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, i[0], 3'd7);
            chk_all("st_hold", 8'h0D, 3'd4, 1, 0);
        end
        for (int i = 4; i < 7; i++) begin
            cyc(0, 0, 1, 0, frame[i], 3'd0);
            chk({"st_nodone"}, {7'd0, done}, 8'h00);
        end
        cyc(0, 0, 1, 0, frame[7], 3'd0);
        chk_all("st_end", 8'h4D, 3'd0, 0, 1);
        cyc(0, 0, 0, 0, 0, 3'd0);
        chk_all("st_idle", 8'h4D, 3'd0, 0, 0);

        // Reset after five captured bits aborts the frame.
        cyc(0, 0, 1, 1, 0, 3'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, i[0] ? 1'b0 : 1'b1, 3'd0);
        chk_all("rm_pre", 8'h15, 3'd5, 1, 0);
        cyc(1, 0, 1, 0, 1, 3'd0);
        chk_all("rm_rst", 8'h00, 3'd0, 0, 0);
        cyc(0, 0, 1, 0, 1, 3'd0);
        chk_all("rm_after", 8'h00, 3'd0, 0, 0);

        // Fresh frame 8'hA5: exactly one done pulse.
        frame = 8'hA5; exp_d = 8'h00; done_seen = 0;
        cyc(0, 0, 1, 1, 1, 3'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, frame[i], 3'd0);
            exp_d[i] = frame[i];
            chk("a5_data", data, exp_d);
            if (done) done_seen++;
        end
        cyc(0, 0, 1, 0, 0, 3'd0);
        if (done) done_seen++;
        chk("a5_final", data, 8'hA5);
        chk("a5_dones", done_seen[7:0], 8'd1);

        // Ignored controls in SHIFT and DONE.
        frame = 8'h4D;
        cyc(0, 0, 1, 1, 0, 3'd0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1'(i % 2), i[0], frame[i], 3'd7);
        chk_all("ig_done", 8'h4D, 3'd0, 0, 1);
        cyc(0, 0, 1, 1, 1, 3'd0);
        chk_all("ig_nore", 8'h4D, 3'd0, 0, 0);
        cyc(0, 0, 1, 1, 1, 3'd0);
        chk_all("ig_new", 8'h00, 3'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
